// File: rtl/md_seq_ctrl.sv
// Sequencer for an iterative unsigned multiply/divide unit beside the EX-stage ALU.
// It performs one shift-add or restoring-divide step per cycle and reports the result with a one-cycle done pulse.
module md_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t             state_reg, state_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic [WIDTH-1:0]   result_reg, result_next;

  logic [1:0]         op_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [2*WIDTH-1:0] prod_reg;
  logic [WIDTH-1:0]   rem_reg;
  logic [WIDTH-1:0]   quo_reg;

  logic               load;
  logic               step;
  logic               finish;
  logic               div_zero;

  // Multiply step: the product's upper half accumulates and the whole register shifts right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_step;
  // Divide step: bring in the next dividend bit, then try to subtract the divisor.
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quo_step;
  logic               unused_bits;

  assign mul_sum   = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} + (prod_reg[0] ? {1'b0, a_reg} : '0);
  assign prod_step = {mul_sum, prod_reg[WIDTH-1:1]};

  assign div_shift = {rem_reg, quo_reg[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, b_reg};
  assign rem_step  = div_diff[WIDTH+1] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
  assign quo_step  = {quo_reg[WIDTH-2:0], ~div_diff[WIDTH+1]};
  // After a successful subtract the difference is below the divisor, so bit WIDTH is always zero.
  assign unused_bits = div_diff[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    div_zero   = 1'b0;
    stall      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start && !flush) begin
          load      = 1'b1;
          stall     = 1'b1;
          busy_next = 1'b1;
          if (op[1] && (src_b == '0)) begin
            div_zero   = 1'b1;
            done_next  = 1'b1;
            state_next = S_DONE;
          end else begin
            state_next = S_CALC;
          end
        end
      end
      S_CALC: begin
        stall = 1'b1;
        if (flush) begin
          state_next = S_IDLE;
        end else begin
          step      = 1'b1;
          busy_next = 1'b1;
          if (cnt_reg == LAST_ITER) begin
            finish     = 1'b1;
            done_next  = 1'b1;
            state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        // The pulse is already on the output; flush or not, the next cycle is IDLE.
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    result_next = result_reg;
    if (div_zero) begin
      result_next = op[0] ? src_a : '1;
    end else if (finish) begin
      case (op_reg)
        OP_MUL:   result_next = prod_step[WIDTH-1:0];
        OP_MULHU: result_next = prod_step[2*WIDTH-1:WIDTH];
        OP_DIVU:  result_next = quo_step;
        default:  result_next = rem_step;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      cnt_reg    <= '0;
      prod_reg   <= '0;
      rem_reg    <= '0;
      quo_reg    <= '0;
      result_reg <= '0;
    end else begin
      if (load) begin
        op_reg   <= op;
        a_reg    <= src_a;
        b_reg    <= src_b;
        cnt_reg  <= '0;
        prod_reg <= {{WIDTH{1'b0}}, src_b};
        rem_reg  <= '0;
        quo_reg  <= src_a;
      end else if (step) begin
        cnt_reg  <= cnt_reg + CNT_W'(1);
        prod_reg <= prod_step;
        rem_reg  <= rem_step;
        quo_reg  <= quo_step;
      end
      if (div_zero || finish) begin
        result_reg <= result_next;
      end
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_md_seq_ctrl.sv
// Testbench for md_seq_ctrl: directed and random operations are checked against an arithmetic reference model.
// It also checks latency, stall, flush, the ignored mid-operation start, and asynchronous reset.
module tb_md_seq_ctrl;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result;

  int tests;
  int fails;

  md_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .flush  (flush),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Results from plain wide arithmetic. Division by zero follows the RISC-V convention.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (o)
      2'b00:   return {32'b0, p[31:0]};
      2'b01:   return {32'b0, p[63:32]};
      2'b10:   return (b == 0) ? 64'h0000_0000_FFFF_FFFF : {32'b0, a / b};
      default: return (b == 0) ? {32'b0, a} : {32'b0, a % b};
    endcase
  endfunction

  task automatic idle_watch(input int cycles);
    int dcnt;
    int bcnt;
    dcnt = 0;
    bcnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done) dcnt++;
      if (busy) bcnt++;
    end
    check("idle_no_done", dcnt, 0);
    check("idle_no_busy", bcnt, 0);
  endtask

  // Issue one operation. flush_at and poke_at give the post-acceptance cycle index; use -1 for none.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, input int poke_at);
    logic [63:0] exp_res;
    logic [31:0] prev_res;
    int exp_n;
    int n;
    int stall_cnt;
    bit seen;
    exp_res = model(o, a, b);
    exp_n   = (o[1] && b == 0) ? 1 : WIDTH + 1;
    @(negedge clk);
    check("pre_idle_busy", busy, 0);
    check("pre_idle_done", done, 0);
    prev_res = result;
    op = o; src_a = a; src_b = b; start = 1'b1; flush = 1'b0;
    #1;
    check("stall_on_start", stall, 1);
    stall_cnt = 1;
    n = 0;
    seen = 0;
    while (!seen && n < WIDTH + 8) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      flush = 1'b0;
      if (done) begin
        seen = 1;
        check("busy_in_done", busy, 1);
        check("stall_in_done", stall, 0);
      end else if (stall) begin
        stall_cnt++;
      end
      if (!seen) begin
        src_a = $urandom;
        src_b = $urandom;
        op    = 2'($urandom);
        if (n == poke_at) begin
          start = 1'b1;
        end
        if (n == flush_at) begin
          flush = 1'b1;
          #1;
          check("stall_while_flush", stall, 1);
          @(negedge clk);
          flush = 1'b0;
          check("flush_busy", busy, 0);
          check("flush_done", done, 0);
          check("flush_result_kept", result, prev_res);
          idle_watch(WIDTH + 4);
          return;
        end
      end
    end
    start = 1'b0;
    check("done_seen", seen, 1);
    check("latency", n, exp_n);
    check("stall_cycles", stall_cnt, exp_n);
    check("result", result, exp_res);
    $display("[TB] op=%0d a=%08h b=%08h -> result=%08h latency=%0d", o, a, b, result, n);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op    = 2'b00;
    src_a = '0;
    src_b = '0;

    // Reset state
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_stall", stall, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // A start raised together with flush in IDLE is dropped.
    @(negedge clk);
    op = 2'b00; src_a = 32'd5; src_b = 32'd5; start = 1'b1; flush = 1'b1;
    #1;
    check("start_flush_stall", stall, 0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("start_flush_ignored", busy, 0);

    // MUL 7*6
    run_op(2'b00, 32'd7, 32'd6, -1, -1);
    check("mul_7x6", result, 32'd42);

    // MULHU and MUL on all ones
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
    check("mulhu_ones", result, 32'hFFFF_FFFE);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
    check("mul_ones", result, 32'h0000_0001);

    // DIVU and REMU back to back
    run_op(2'b10, 32'd100, 32'd7, -1, -1);
    check("divu_100_7", result, 32'd14);
    run_op(2'b11, 32'd100, 32'd7, -1, -1);
    check("remu_100_7", result, 32'd2);

    // Divide by zero
    run_op(2'b10, 32'd5, 32'd0, -1, -1);
    check("divu_by_zero", result, 32'hFFFF_FFFF);
    run_op(2'b11, 32'd5, 32'd0, -1, -1);
    check("remu_by_zero", result, 32'd5);

    // Flush at iteration 10 of a MUL
    run_op(2'b00, 32'd1234, 32'd5678, 11, -1);

    // A start pulsed while busy is neither taken nor queued.
    run_op(2'b10, 32'd1000, 32'd3, -1, 4);
    check("poke_result", result, 32'd333);
    idle_watch(WIDTH + 4);

    // Asynchronous reset in the middle of CALC
    @(negedge clk);
    op = 2'b00; src_a = 32'd123; src_b = 32'd456; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_result", result, 0);
    check("async_rst_stall", stall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b00, 32'd3, 32'd3, -1, -1);
    check("mul_3x3_after_rst", result, 32'd9);

    // Random operations
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 1000));
      run_op(ro, ra, rb, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
